// File: rtl/forth_pkg.sv
// Shared Forth core definitions: data width, stack opcodes, opcode lookup helpers.
// No logic, no latency; consumed by the control unit and the data stack.
// No flow control: every opcode is accepted in the cycle it is issued.
package forth_pkg;

    localparam int WIDTH = 16;

    typedef logic [3:0] stackop_t;

    localparam stackop_t STK_NOP    = 4'b0000;
    localparam stackop_t STK_PUSH   = 4'b0001;
    localparam stackop_t STK_DROP   = 4'b0010;
    localparam stackop_t STK_DUP    = 4'b0011;
    localparam stackop_t STK_SWAP   = 4'b0100;
    localparam stackop_t STK_OVER   = 4'b0101;
    localparam stackop_t STK_NIP    = 4'b0110;
    localparam stackop_t STK_ROT    = 4'b0111;
    localparam stackop_t STK_UNARY  = 4'b1000;
    localparam stackop_t STK_BINARY = 4'b1001;

    // Number of entries an opcode needs on the stack before it may execute.
    // Reserved codes behave as NOP and need nothing.
    function automatic logic [1:0] stk_min_depth(input stackop_t op);
        logic [1:0] need;
        case (op)
            STK_DROP, STK_DUP, STK_UNARY:              need = 2'd1;
            STK_SWAP, STK_OVER, STK_NIP, STK_BINARY:   need = 2'd2;
            STK_ROT:                                   need = 2'd3;
            default:                                   need = 2'd0;
        endcase
        return need;
    endfunction

    // Change in entry count caused by an opcode: -1, 0 or +1.
    function automatic logic signed [1:0] stk_depth_delta(input stackop_t op);
        logic signed [1:0] delta;
        case (op)
            STK_PUSH, STK_DUP, STK_OVER:           delta = 2'sd1;
            STK_DROP, STK_NIP, STK_BINARY:         delta = -2'sd1;
            default:                               delta = 2'sd0;
        endcase
        return delta;
    endfunction

endpackage

// File: rtl/data_stack_if.sv
// Control-unit / ALU facing bundle of the data stack: opcode, literal, ALU result in; stack view out.
// Outputs are registered at the stack, so they change one rising edge after an opcode is issued.
// No backpressure: the stack accepts one opcode per cycle, every cycle.
interface data_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [3:0]       f_stackop;
    logic [WIDTH-1:0] i_DATA;
    logic [WIDTH-1:0] i_ALU;
    logic [WIDTH-1:0] o_TOS;
    logic [WIDTH-1:0] o_NOS;
    logic [DW-1:0]    o_DEPTH;
    logic             o_EMPTY;
    logic             o_FULL;
    logic             o_UNDERFLOW;
    logic             o_OVERFLOW;

    // master: control unit + ALU side
    modport master (
        output f_stackop, i_DATA, i_ALU,
        input  o_TOS, o_NOS, o_DEPTH, o_EMPTY, o_FULL, o_UNDERFLOW, o_OVERFLOW
    );

    // slave: the data stack itself
    modport slave (
        input  f_stackop, i_DATA, i_ALU,
        output o_TOS, o_NOS, o_DEPTH, o_EMPTY, o_FULL, o_UNDERFLOW, o_OVERFLOW
    );

endinterface

// File: rtl/stack_spill_rf.sv
// Spill register file for stack entries below NOS; ports: c_CLOCK, we/waddr/wdata, raddr/rdata.
// Read is combinational (zero latency); write lands on the rising edge.
// No flow control; contents are never reset, validity is tracked by the stack depth.
module stack_spill_rf #(
    parameter int WIDTH   = 16,
    parameter int ENTRIES = 14,
    parameter int AW      = 4
) (
    input  logic             c_CLOCK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge c_CLOCK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Forth data stack: TOS/NOS registers feeding the ALU, deeper entries in a spill file.
// Ports: c_CLOCK, c_RESET (sync, active-high), bus (opcode/literal/ALU result in, stack view out).
// One opcode per cycle, results visible one edge later; no backpressure, illegal ops only raise sticky flags.
module data_stack
    import forth_pkg::*;
#(
    parameter int WIDTH = forth_pkg::WIDTH,
    parameter int DEPTH = 16
) (
    input  logic         c_CLOCK,
    input  logic         c_RESET,
    data_stack_if.slave  bus
);

    localparam int DW      = $clog2(DEPTH + 1);
    localparam int ENTRIES = DEPTH - 2;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             unf_q, unf_d;
    logic             ovf_q, ovf_d;

    logic             spill_we;
    logic [AW-1:0]    spill_waddr;
    logic [AW-1:0]    spill_raddr;
    logic [AW-1:0]    spill_push_addr;
    logic [WIDTH-1:0] spill_rdata;
    logic [WIDTH-1:0] third;

    logic [DW-1:0]     need;
    logic signed [1:0] delta;

    // Top of spill lives at depth-3; a grow writes the old NOS one slot above it.
    assign spill_raddr     = AW'(depth_q - DW'(3));
    assign spill_push_addr = AW'(depth_q - DW'(2));

    // The spill slot is stale whenever fewer than three entries exist; reveal 0 instead.
    assign third = (depth_q >= DW'(3)) ? spill_rdata : '0;

    assign need  = DW'(stk_min_depth(bus.f_stackop));
    assign delta = stk_depth_delta(bus.f_stackop);

    always_comb begin
        tos_d       = tos_q;
        nos_d       = nos_q;
        depth_d     = depth_q;
        unf_d       = unf_q;
        ovf_d       = ovf_q;
        spill_we    = 1'b0;
        spill_waddr = spill_push_addr;

        if (depth_q < need) begin
            unf_d = 1'b1;
        end else if (delta == 2'sd1 && depth_q == DW'(DEPTH)) begin
            ovf_d = 1'b1;
        end else begin
            depth_d = depth_q + DW'(delta);

            // Every growing op pushes the old NOS down; below depth 2 NOS is
            // just the revealed zero and nothing needs saving.
            if (delta == 2'sd1 && depth_q >= DW'(2)) begin
                spill_we = 1'b1;
            end

            case (bus.f_stackop)
                STK_PUSH: begin
                    tos_d = bus.i_DATA;
                    nos_d = tos_q;
                end
                STK_DROP: begin
                    tos_d = nos_q;
                    nos_d = third;
                end
                STK_DUP: begin
                    nos_d = tos_q;
                end
                STK_SWAP: begin
                    tos_d = nos_q;
                    nos_d = tos_q;
                end
                STK_OVER: begin
                    tos_d = nos_q;
                    nos_d = tos_q;
                end
                STK_NIP: begin
                    nos_d = third;
                end
                STK_ROT: begin
                    // Third entry comes up to TOS while old NOS takes its slot
                    // in the same spill location: read-before-write in one cycle.
                    tos_d       = third;
                    nos_d       = tos_q;
                    spill_we    = 1'b1;
                    spill_waddr = spill_raddr;
                end
                STK_UNARY: begin
                    tos_d = bus.i_ALU;
                end
                STK_BINARY: begin
                    tos_d = bus.i_ALU;
                    nos_d = third;
                end
                default: begin
                end
            endcase
        end

        empty_d = (depth_d == '0);
        full_d  = (depth_d == DW'(DEPTH));
    end

    always_ff @(posedge c_CLOCK) begin
        if (c_RESET) begin
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
        end
    end

    // Reset wins over a coincident opcode, including its spill write.
    stack_spill_rf #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_spill (
        .c_CLOCK (c_CLOCK),
        .we      (spill_we & ~c_RESET),
        .waddr   (spill_waddr),
        .wdata   (nos_q),
        .raddr   (spill_raddr),
        .rdata   (spill_rdata)
    );

    assign bus.o_TOS       = tos_q;
    assign bus.o_NOS       = nos_q;
    assign bus.o_DEPTH     = depth_q;
    assign bus.o_EMPTY     = empty_q;
    assign bus.o_FULL      = full_q;
    assign bus.o_UNDERFLOW = unf_q;
    assign bus.o_OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed scenarios plus randomized opcodes vs a queue model.
// Checks one rising edge after each issued opcode.
// Opcodes are issued every cycle back to back.
module tb_data_stack;
    import forth_pkg::*;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int DW = $clog2(D + 1);
    localparam int VW = 2 * W + DW + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

    data_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .c_CLOCK (clk),
        .c_RESET (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: element 0 is the top of the stack.
    logic [W-1:0] mq[$];
    bit           m_unf;
    bit           m_ovf;

    function automatic logic [W-1:0] m_at(input int i);
        return (i < mq.size()) ? mq[i] : '0;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_at(0), m_at(1), DW'(mq.size()), (mq.size() == 0), (mq.size() == D), m_unf, m_ovf};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.o_TOS, bus.o_NOS, bus.o_DEPTH, bus.o_EMPTY, bus.o_FULL, bus.o_UNDERFLOW, bus.o_OVERFLOW};
    endfunction

    task automatic model_apply(input logic [3:0] op, input logic [W-1:0] dat,
                               input logic [W-1:0] alu, input bit r);
        int need;
        int grow;
        logic [W-1:0] t;
        if (r) begin
            mq.delete();
            m_unf = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        case (op)
            4'd1: begin need = 0; grow = 1;  end
            4'd2: begin need = 1; grow = -1; end
            4'd3: begin need = 1; grow = 1;  end
            4'd4: begin need = 2; grow = 0;  end
            4'd5: begin need = 2; grow = 1;  end
            4'd6: begin need = 2; grow = -1; end
            4'd7: begin need = 3; grow = 0;  end
            4'd8: begin need = 1; grow = 0;  end
            4'd9: begin need = 2; grow = -1; end
            default: begin need = 0; grow = 0; end
        endcase
        if (mq.size() < need) begin
            m_unf = 1'b1;
        end else if (grow == 1 && mq.size() == D) begin
            m_ovf = 1'b1;
        end else begin
            case (op)
                4'd1: mq.push_front(dat);
                4'd2: void'(mq.pop_front());
                4'd3: mq.push_front(mq[0]);
                4'd4: begin t = mq[0]; mq[0] = mq[1]; mq[1] = t; end
                4'd5: mq.push_front(mq[1]);
                4'd6: mq.delete(1);
                4'd7: begin t = mq[2]; mq.delete(2); mq.push_front(t); end
                4'd8: mq[0] = alu;
                4'd9: begin void'(mq.pop_front()); mq[0] = alu; end
                default: ;
            endcase
        end
    endtask

    // Issue one opcode for one cycle and advance the model; sampling point is #1 after the edge.
    task automatic step(input logic [3:0] op, input logic [W-1:0] dat,
                        input logic [W-1:0] alu, input bit r);
        @(negedge clk);
        rst           = r;
        bus.f_stackop = op;
        bus.i_DATA    = dat;
        bus.i_ALU     = alu;
        @(posedge clk);
        #1;
        model_apply(op, dat, alu, r);
    endtask

    task automatic test_reset();
        step(STK_PUSH, 16'h1234, '0, 1'b1);
        checks++;
        if (obs_vec() !== {32'h0, 5'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_values: got=%h want=%h", obs_vec(), {32'h0, 5'd0, 4'b1000});
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_push_basic();
        step(STK_NOP, '0, '0, 1'b1);
        step(STK_PUSH, 16'd5, '0, 1'b0);
        step(STK_PUSH, 16'd7, '0, 1'b0);
        checks++;
        if (bus.o_TOS !== 16'd7 || bus.o_NOS !== 16'd5 || bus.o_DEPTH !== 5'd2 || bus.o_EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL push_basic: got tos=%0d nos=%0d depth=%0d empty=%b want 7 5 2 0",
                     bus.o_TOS, bus.o_NOS, bus.o_DEPTH, bus.o_EMPTY);
        end
    endtask

    task automatic test_rot();
        step(STK_NOP, '0, '0, 1'b1);
        step(STK_PUSH, 16'd1, '0, 1'b0);
        step(STK_PUSH, 16'd2, '0, 1'b0);
        step(STK_PUSH, 16'd3, '0, 1'b0);
        step(STK_ROT, '0, '0, 1'b0);
        checks++;
        if (bus.o_TOS !== 16'd1 || bus.o_NOS !== 16'd3) begin
            errors++;
            $display("FAIL rot: got tos=%0d nos=%0d want 1 3", bus.o_TOS, bus.o_NOS);
        end
        step(STK_DROP, '0, '0, 1'b0);
        checks++;
        if (bus.o_NOS !== 16'd2) begin
            errors++;
            $display("FAIL rot_third: got nos=%0d want 2", bus.o_NOS);
        end
        step(STK_DROP, '0, '0, 1'b0);
        checks++;
        if (bus.o_TOS !== 16'd2 || bus.o_DEPTH !== 5'd1) begin
            errors++;
            $display("FAIL rot_drop: got tos=%0d depth=%0d want 2 1", bus.o_TOS, bus.o_DEPTH);
        end
    endtask

    task automatic test_alu();
        step(STK_NOP, '0, '0, 1'b1);
        step(STK_PUSH, 16'd9, '0, 1'b0);
        step(STK_PUSH, 16'd4, '0, 1'b0);
        step(STK_BINARY, '0, 16'd13, 1'b0);
        checks++;
        if (bus.o_TOS !== 16'd13 || bus.o_NOS !== 16'd0 || bus.o_DEPTH !== 5'd1) begin
            errors++;
            $display("FAIL binary: got tos=%0d nos=%0d depth=%0d want 13 0 1", bus.o_TOS, bus.o_NOS, bus.o_DEPTH);
        end
        step(STK_UNARY, '0, 16'hFFF3, 1'b0);
        checks++;
        if (bus.o_TOS !== 16'hFFF3 || bus.o_DEPTH !== 5'd1) begin
            errors++;
            $display("FAIL unary: got tos=%h depth=%0d want fff3 1", bus.o_TOS, bus.o_DEPTH);
        end
    endtask

    task automatic test_underflow();
        step(STK_NOP, '0, '0, 1'b1);
        step(STK_DROP, '0, '0, 1'b0);
        checks++;
        if (bus.o_UNDERFLOW !== 1'b1 || bus.o_DEPTH !== 5'd0 || bus.o_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL underflow: got unf=%b depth=%0d empty=%b want 1 0 1",
                     bus.o_UNDERFLOW, bus.o_DEPTH, bus.o_EMPTY);
        end
        step(STK_PUSH, 16'd6, '0, 1'b0);
        checks++;
        if (bus.o_TOS !== 16'd6 || bus.o_UNDERFLOW !== 1'b1 || bus.o_DEPTH !== 5'd1) begin
            errors++;
            $display("FAIL underflow_sticky: got tos=%0d unf=%b depth=%0d want 6 1 1",
                     bus.o_TOS, bus.o_UNDERFLOW, bus.o_DEPTH);
        end
    endtask

    task automatic test_full();
        step(STK_NOP, '0, '0, 1'b1);
        for (int i = 1; i <= D; i++) begin
            step(STK_PUSH, W'(i), '0, 1'b0);
            checks++;
            if (bus.o_FULL !== (i == D)) begin
                errors++;
                $display("FAIL full_flag: push %0d got full=%b want %b", i, bus.o_FULL, (i == D));
            end
        end
        step(STK_PUSH, 16'd99, '0, 1'b0);
        checks++;
        if (bus.o_OVERFLOW !== 1'b1 || bus.o_TOS !== 16'd16 || bus.o_DEPTH !== 5'd16) begin
            errors++;
            $display("FAIL overflow: got ovf=%b tos=%0d depth=%0d want 1 16 16",
                     bus.o_OVERFLOW, bus.o_TOS, bus.o_DEPTH);
        end
        for (int k = 1; k <= D - 1; k++) begin
            step(STK_DROP, '0, '0, 1'b0);
            checks++;
            if (bus.o_TOS !== W'(D - k) || bus.o_DEPTH !== DW'(D - k)) begin
                errors++;
                $display("FAIL lifo_drop: drop %0d got tos=%0d depth=%0d want %0d %0d",
                         k, bus.o_TOS, bus.o_DEPTH, D - k, D - k);
            end
        end
        checks++;
        if (bus.o_NOS !== 16'd0 || bus.o_OVERFLOW !== 1'b1 || bus.o_FULL !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: got nos=%0d ovf=%b full=%b want 0 1 0", bus.o_NOS, bus.o_OVERFLOW, bus.o_FULL);
        end
    endtask

    task automatic test_reset_priority();
        step(STK_NOP, '0, '0, 1'b1);
        step(STK_PUSH, 16'd11, '0, 1'b0);
        step(STK_PUSH, 16'd22, '0, 1'b0);
        step(STK_PUSH, 16'd33, '0, 1'b0);
        step(STK_PUSH, 16'd44, '0, 1'b1);
        checks++;
        if (obs_vec() !== {32'h0, 5'd0, 4'b1000}) begin
            errors++;
            $display("FAIL reset_over_push: got=%h want=%h", obs_vec(), {32'h0, 5'd0, 4'b1000});
        end
        step(STK_PUSH, 16'd8, '0, 1'b0);
        checks++;
        if (bus.o_TOS !== 16'd8 || bus.o_NOS !== 16'd0 || bus.o_DEPTH !== 5'd1) begin
            errors++;
            $display("FAIL push_after_reset: got tos=%0d nos=%0d depth=%0d want 8 0 1",
                     bus.o_TOS, bus.o_NOS, bus.o_DEPTH);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        bit r;
        step(STK_NOP, '0, '0, 1'b1);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 35) op = STK_PUSH;
            else op = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 199) == 0);
            step(op, W'($urandom), W'($urandom), r);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_op: n=%0d op=%0d got=%h want=%h", n, op, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.f_stackop = STK_NOP;
        bus.i_DATA    = '0;
        bus.i_ALU     = '0;
        m_unf         = 1'b0;
        m_ovf         = 1'b0;
        test_reset();
        test_push_basic();
        test_rot();
        test_alu();
        test_underflow();
        test_full();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
